// File: rtl/regfile_scoreboard.sv
// Parametrised register file with hardwired-zero register, optional write-to-read
// bypass, and a per-register busy scoreboard for destination reservation.
module regfile_scoreboard #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned ZERO_REG = DEPTH - 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         RegWrite,
  input  logic [ADDR_W-1:0]            WriteRegister,
  input  logic [WIDTH-1:0]             WriteData,
  input  logic [RD_PORTS*ADDR_W-1:0]   ReadRegister,
  output logic [RD_PORTS*WIDTH-1:0]    ReadData,
  output logic [RD_PORTS-1:0]          ReadReady,
  input  logic                         Reserve,
  input  logic [ADDR_W-1:0]            ReserveRegister,
  output logic                         ReserveGrant
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wr_en_c;
  logic              rsv_set_c;
  logic [ADDR_W-1:0] rd_addr_c [RD_PORTS];

  function automatic logic is_valid(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // A ZERO_REG outside the array disables the hardwired-zero register.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG < DEPTH) && (32'(a) == ZERO_REG);
  endfunction

  assign wr_en_c = RegWrite && is_valid(WriteRegister) && !is_zero(WriteRegister);

  // Grant: zero register always, otherwise a free register or one freed this cycle.
  always_comb begin
    ReserveGrant = 1'b0;
    rsv_set_c    = 1'b0;
    if (Reserve) begin
      if (is_zero(ReserveRegister)) begin
        ReserveGrant = 1'b1;
      end else if (is_valid(ReserveRegister)) begin
        ReserveGrant = !busy_q[ReserveRegister] ||
                       (wr_en_c && (WriteRegister == ReserveRegister));
        rsv_set_c    = ReserveGrant;
      end
    end
  end

  // Writeback clears busy; a same-cycle reservation is applied after, so it wins.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (wr_en_c && (WriteRegister == ADDR_W'(i))) busy_d[i] = 1'b0;
      if (rsv_set_c && (ReserveRegister == ADDR_W'(i))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (wr_en_c && (WriteRegister == ADDR_W'(i))) mem_q[i] <= WriteData;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < int'(RD_PORTS); p++) begin
      rd_addr_c[p] = ReadRegister[p*ADDR_W +: ADDR_W];
    end
  end

  // Read ports: zero/out-of-range, then bypass, then stored value with busy status.
  always_comb begin
    ReadData  = '0;
    ReadReady = '1;
    for (int p = 0; p < int'(RD_PORTS); p++) begin
      if (!is_valid(rd_addr_c[p]) || is_zero(rd_addr_c[p])) begin
        ReadData[p*WIDTH +: WIDTH] = '0;
        ReadReady[p]               = 1'b1;
      end else if ((BYPASS != 0) && wr_en_c && (WriteRegister == rd_addr_c[p])) begin
        ReadData[p*WIDTH +: WIDTH] = WriteData;
        ReadReady[p]               = 1'b1;
      end else begin
        ReadData[p*WIDTH +: WIDTH] = mem_q[rd_addr_c[p]];
        ReadReady[p]               = !busy_q[rd_addr_c[p]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default config, a no-bypass copy, and a
// 20-entry / 3-port copy with register 0 hardwired to zero.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // Instance A: defaults (32 x 64, 2 ports, zero reg 31, bypass)
  logic         a_we, a_rsv, a_gnt;
  logic [4:0]   a_wa, a_rr;
  logic [63:0]  a_wd;
  logic [9:0]   a_ra;
  logic [127:0] a_rd;
  logic [1:0]   a_rdy;

  regfile_scoreboard u_dut_a (
    .clk(clk), .reset(reset), .RegWrite(a_we), .WriteRegister(a_wa), .WriteData(a_wd),
    .ReadRegister(a_ra), .ReadData(a_rd), .ReadReady(a_rdy),
    .Reserve(a_rsv), .ReserveRegister(a_rr), .ReserveGrant(a_gnt)
  );

  // Instance B: no bypass
  logic         b_we, b_rsv, b_gnt;
  logic [4:0]   b_wa, b_rr;
  logic [63:0]  b_wd;
  logic [9:0]   b_ra;
  logic [127:0] b_rd;
  logic [1:0]   b_rdy;

  regfile_scoreboard #(.BYPASS(0)) u_dut_b (
    .clk(clk), .reset(reset), .RegWrite(b_we), .WriteRegister(b_wa), .WriteData(b_wd),
    .ReadRegister(b_ra), .ReadData(b_rd), .ReadReady(b_rdy),
    .Reserve(b_rsv), .ReserveRegister(b_rr), .ReserveGrant(b_gnt)
  );

  // Instance C: 20 entries, 3 ports, register 0 is zero
  logic         c_we, c_rsv, c_gnt;
  logic [4:0]   c_wa, c_rr;
  logic [63:0]  c_wd;
  logic [14:0]  c_ra;
  logic [191:0] c_rd;
  logic [2:0]   c_rdy;

  regfile_scoreboard #(.DEPTH(20), .RD_PORTS(3), .ZERO_REG(0)) u_dut_c (
    .clk(clk), .reset(reset), .RegWrite(c_we), .WriteRegister(c_wa), .WriteData(c_wd),
    .ReadRegister(c_ra), .ReadData(c_rd), .ReadReady(c_rdy),
    .Reserve(c_rsv), .ReserveRegister(c_rr), .ReserveGrant(c_gnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next active edge; inputs change and outputs settle off-edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_we = 0; a_rsv = 0; a_wa = '0; a_rr = '0; a_wd = '0; a_ra = '0;
    b_we = 0; b_rsv = 0; b_wa = '0; b_rr = '0; b_wd = '0; b_ra = '0;
    c_we = 0; c_rsv = 0; c_wa = '0; c_rr = '0; c_wd = '0; c_ra = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state on every address, both ports
    for (int a = 0; a < 32; a++) begin
      a_ra = {5'(31 - a), 5'(a)};
      #1;
      check("rst_rd_p0", a_rd[63:0], 64'h0);
      check("rst_rd_p1", a_rd[127:64], 64'h0);
      check("rst_rdy", 64'(a_rdy), 64'h3);
    end

    // Write then reset clears contents
    a_we = 1; a_wa = 5; a_wd = 64'hDEAD_BEEF;
    step();
    a_we = 0; a_ra = {5'd0, 5'd5};
    #1 check("wr_r5", a_rd[63:0], 64'hDEAD_BEEF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1 check("rst_r5", a_rd[63:0], 64'h0);
    check("rst_r5_rdy", 64'(a_rdy), 64'h3);

    // Same-cycle bypass
    a_we = 1; a_wa = 7; a_wd = 64'h1234; a_ra = {5'd0, 5'd7};
    #1 check("byp_data", a_rd[63:0], 64'h1234);
    check("byp_rdy", 64'(a_rdy[0]), 64'h1);
    step();
    a_we = 0;
    #1 check("byp_after", a_rd[63:0], 64'h1234);

    // Zero register: writes dropped, never bypassed, reservation granted without state
    a_we = 1; a_wa = 31; a_wd = '1; a_ra = {5'd0, 5'd31};
    #1 check("zero_nobyp", a_rd[63:0], 64'h0);
    step();
    a_we = 0;
    #1 check("zero_rd", a_rd[63:0], 64'h0);
    a_rsv = 1; a_rr = 31;
    #1 check("zero_gnt", 64'(a_gnt), 64'h1);
    step();
    a_rsv = 0;
    #1 check("zero_rdy", 64'(a_rdy[0]), 64'h1);

    // Reserve r3, deny while busy, writeback releases it
    a_rsv = 1; a_rr = 3; a_ra = {5'd0, 5'd3};
    #1 check("r3_gnt", 64'(a_gnt), 64'h1);
    check("r3_rdy_pre", 64'(a_rdy[0]), 64'h1);
    step();
    check("r3_deny", 64'(a_gnt), 64'h0);
    check("r3_busy", 64'(a_rdy[0]), 64'h0);
    a_rsv = 0; a_we = 1; a_wa = 3; a_wd = 64'd9;
    #1 check("r3_wr_byp_rdy", 64'(a_rdy[0]), 64'h1);
    check("r3_wr_byp_data", a_rd[63:0], 64'd9);
    step();
    a_we = 0;
    #1 check("r3_rdy", 64'(a_rdy[0]), 64'h1);
    check("r3_data", a_rd[63:0], 64'd9);

    // Busy r4: write and reserve in the same cycle, reservation wins
    a_rsv = 1; a_rr = 4;
    step();
    a_we = 1; a_wa = 4; a_wd = 64'hA5; a_ra = {5'd3, 5'd4};
    #1 check("r4_gnt", 64'(a_gnt), 64'h1);
    check("r4_byp", a_rd[63:0], 64'hA5);
    step();
    a_we = 0; a_rsv = 0;
    #1 check("r4_data", a_rd[63:0], 64'hA5);
    check("r4_busy", 64'(a_rdy), 64'h2);
    check("r3_p1", a_rd[127:64], 64'd9);

    // Reset mid-operation drops reservations and data
    a_rsv = 1; a_rr = 10;
    step();
    a_rsv = 0; a_ra = {5'd7, 5'd10};
    #1 check("r10_busy", 64'(a_rdy[0]), 64'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1 check("mid_rst_rdy", 64'(a_rdy), 64'h3);
    check("mid_rst_r7", a_rd[127:64], 64'h0);
    a_rsv = 1; a_rr = 10;
    #1 check("mid_rst_gnt", 64'(a_gnt), 64'h1);
    a_rsv = 0;

    // No bypass: old value during write cycle, new value next cycle
    b_we = 1; b_wa = 7; b_wd = 64'h1234; b_ra = {5'd0, 5'd7};
    #1 check("nb_old", b_rd[63:0], 64'h0);
    step();
    b_we = 0;
    #1 check("nb_new", b_rd[63:0], 64'h1234);
    b_rsv = 1; b_rr = 2; b_ra = {5'd0, 5'd2};
    step();
    b_rsv = 0; b_we = 1; b_wa = 2; b_wd = 64'd5;
    #1 check("nb_busy_wr", 64'(b_rdy[0]), 64'h0);
    step();
    b_we = 0;
    #1 check("nb_rdy", 64'(b_rdy[0]), 64'h1);
    check("nb_data", b_rd[63:0], 64'd5);

    // Small config: out-of-range address and zero register at index 0
    c_ra = {5'd0, 5'd0, 5'd25};
    #1 check("oor_rd", c_rd[63:0], 64'h0);
    check("oor_rdy", 64'(c_rdy), 64'h7);
    c_we = 1; c_wa = 25; c_wd = 64'hFF; c_rsv = 1; c_rr = 25;
    #1 check("oor_gnt", 64'(c_gnt), 64'h0);
    step();
    c_rsv = 1; c_rr = 0; c_we = 1; c_wa = 0; c_wd = 64'd77;
    #1 check("z0_gnt", 64'(c_gnt), 64'h1);
    check("oor_rd2", c_rd[63:0], 64'h0);
    step();
    c_rsv = 0; c_wa = 1; c_wd = 64'd1;
    step();
    c_wa = 2; c_wd = 64'd2;
    step();
    c_wa = 19; c_wd = 64'd19;
    step();
    c_we = 0; c_ra = {5'd19, 5'd2, 5'd1};
    #1 check("c_p0", c_rd[63:0], 64'd1);
    check("c_p1", c_rd[127:64], 64'd2);
    check("c_p2", c_rd[191:128], 64'd19);
    check("c_rdy", 64'(c_rdy), 64'h7);
    c_ra = {5'd25, 5'd0, 5'd0};
    #1 check("z0_rd", c_rd[63:0], 64'h0);
    check("oor_rd3", c_rd[191:128], 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file for the datapath's decode/writeback stages. It generalises the fixed 32×64, two-read-port file with a hardwired zero register in four ways: configurable width, depth and read-port count; synchronous reset of contents; optional same-cycle write-to-read bypass; and a per-register busy scoreboard that lets the issue logic reserve a destination and learn when its result has been written back.

## Interface
Parameters:
- WIDTH, 64, data bits per register
- DEPTH, 32, number of registers (2..256); ADDR_W = $clog2(DEPTH)
- RD_PORTS, 2, number of independent read ports (1..4)
- ZERO_REG, DEPTH-1, index of the hardwired-zero register; any value ≥ DEPTH disables it
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see the stored value only

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- RegWrite  in  1  write enable
- WriteRegister  in  ADDR_W  write address
- WriteData  in  WIDTH  write data
- ReadRegister  in  RD_PORTS*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
- ReadData  out  RD_PORTS*WIDTH  read data, combinational; port p uses bits [p*WIDTH +: WIDTH]
- ReadReady  out  RD_PORTS  1 = read value on port p is final (not busy)
- Reserve  in  1  request to mark ReserveRegister busy
- ReserveRegister  in  ADDR_W  register to reserve
- ReserveGrant  out  1  combinational; reservation accepted this cycle

## Operation
- Storage: DEPTH×WIDTH flops plus a DEPTH-bit busy vector.
- Reset: all registers load 0 and all busy bits clear. Reset overrides RegWrite and Reserve in the same cycle.
- Write: on a rising clk edge with RegWrite=1, reset=0 and WriteRegister < DEPTH, WriteRegister ≠ ZERO_REG, the register loads WriteData and its busy bit clears.
  - Writes to ZERO_REG or to an address ≥ DEPTH are dropped.
- Read port p, all ports independent and combinational:
  - Address = ZERO_REG or ≥ DEPTH: ReadData = 0, ReadReady = 1.
  - BYPASS=1, RegWrite=1 and WriteRegister equals the read address (valid, not ZERO_REG): ReadData = WriteData and ReadReady = 1, even if busy.
  - Otherwise: ReadData = stored value and ReadReady = !busy[addr].
- Reservation:
  - ReserveGrant = Reserve & (addr is ZERO_REG, or addr < DEPTH and not busy, or addr < DEPTH and RegWrite writes that same addr this cycle).
  - On a grant to a real register, the busy bit sets at the clock edge.
  - A grant to ZERO_REG changes no state.
  - Reserve with addr ≥ DEPTH: no grant.
  - Denied requests change no state; the requester holds Reserve until it is granted.
- Simultaneous write and granted reserve to the same register: data is written and busy ends set, because the reservation wins.
- A write to a non-busy register is legal; it updates data and busy stays 0.

## Timing
- Read latency: 0 cycles (combinational from ReadRegister, and from WriteData/RegWrite when BYPASS=1).
- Write-to-read latency: 1 cycle with BYPASS=0; 0 cycles with BYPASS=1.
- Busy set: visible on ReadReady the cycle after the grant edge.
- Busy clear: visible the cycle after the write edge; with BYPASS=1, ReadReady=1 during the write cycle itself.
- Reset mid-operation: at the reset edge every busy bit clears, all data becomes 0, and any pending reservations are lost. The first cycle after reset deasserts, all ReadData = 0 and ReadReady = all 1s.
- Output values after reset (with no write or reserve active): ReadData = 0, ReadReady = 1, ReserveGrant = Reserve & valid addr.
- No combinational path from Reserve/ReserveRegister to ReadData or ReadReady.

## Test plan
- Reset, then read all 32 addresses on both ports -> every ReadData = 0 and ReadReady = 2'b11; write 64'hDEAD_BEEF to r5, reset next cycle -> r5 reads 0.
- BYPASS=1: RegWrite=1, r7 ← 64'h1234, ReadRegister p0=7 in the same cycle -> ReadData p0 = 64'h1234 that cycle. BYPASS=0: same stimulus -> old value (0) that cycle, 64'h1234 next cycle.
- Write 64'hFFFF… to r31 (ZERO_REG=31) -> reads 0. Reserve r31 -> ReserveGrant=1, ReadReady stays 1.
- Reserve r3 -> grant=1, next cycle ReadReady for r3 = 0. Reserve r3 again -> grant=0. Write r3 ← 9 -> next cycle ReadReady=1 and data=9.
- r4 busy; same cycle RegWrite r4 ← 64'hA5 and Reserve r4 -> grant=1; next cycle r4 = 64'hA5 with ReadReady=0.
- DEPTH=20, RD_PORTS=3, ZERO_REG=0: read addr 25 -> 0/ready; write addr 25 and Reserve addr 25 -> ignored, grant=0; three ports reading r1, r2, r19 after writes 1, 2, 19 -> 1, 2, 19.
